// File: rtl/entrada_nota.sv
// Push-button input stage: synchronizes and debounces btn_ok, captures the note
// switches on each qualified press and emits one registered ok pulse per accepted note.
module entrada_nota #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_NOTAS       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ok,
  input  logic [2:0] sw_nota,
  input  logic       sw_mod,
  input  logic       fim,
  output logic       ok,
  output logic [3:0] nota,
  output logic [2:0] contagem,
  output logic       cheio
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    MAX_CODE = 3'(MAX_NOTAS);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t        state_r, state_next_s;
  logic [1:0]    sync_r;
  logic          btn_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic          capture_s;
  logic          accept_s;
  logic          pend_r;

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_ok};
    end
  end

  assign btn_s = sync_r[1];

  // Debounce state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Debounce next-state logic; capture fires once per qualified press
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (btn_s) begin
          state_next_s = PRESS_WAIT;
          cnt_next_s   = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = HELD;
          capture_s    = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next_s = RELEASE_WAIT;
          cnt_next_s   = '0;
        end else begin
          state_next_s = HELD;
        end
      end
      RELEASE_WAIT: begin
        // A return to 1 here is release bounce, not a new press
        if (btn_s) begin
          state_next_s = HELD;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = IDLE;
        end else begin
          cnt_next_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Rejection by cheio also makes contagem saturate at MAX_NOTAS
  assign accept_s = capture_s & ~fim & ~cheio;
  assign cheio    = (contagem == MAX_CODE);

  // Note capture, note counter and delayed ok pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nota     <= 4'b0000;
      contagem <= 3'd0;
      pend_r   <= 1'b0;
      ok       <= 1'b0;
    end else begin
      ok     <= pend_r;
      pend_r <= accept_s;
      if (accept_s) begin
        nota     <= {sw_mod, sw_nota};
        contagem <= contagem + 3'd1;
      end else begin
        nota     <= nota;
        contagem <= contagem;
      end
    end
  end

endmodule

// File: tb/tb_entrada_nota.sv
// Directed bench for entrada_nota: expected notes are queued at stimulus time and
// popped by a monitor whenever ok pulses; timing and counters are checked inline.
module tb_entrada_nota;

  localparam int D = 16;

  logic       clk;
  logic       reset;
  logic       btn_ok;
  logic [2:0] sw_nota;
  logic       sw_mod;
  logic       fim;
  logic       ok;
  logic [3:0] nota;
  logic [2:0] contagem;
  logic       cheio;

  int         tests;
  int         failed;
  int         ok_count;
  int         oc;
  logic       prev_ok;
  logic [3:0] exp_q[$];
  logic [3:0] exp_nota;

  entrada_nota #(.DEBOUNCE_CYCLES(D), .MAX_NOTAS(5)) dut (
    .clk(clk), .reset(reset), .btn_ok(btn_ok), .sw_nota(sw_nota), .sw_mod(sw_mod),
    .fim(fim), .ok(ok), .nota(nota), .contagem(contagem), .cheio(cheio)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Land just after a falling edge so the monitor has already updated
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Clean press started right before edge 0: check the exact capture and ok timing
  task automatic timed_press(input string tag, input logic [3:0] exp_n, input logic [2:0] exp_c);
    btn_ok = 1'b1;
    wait_n(D + 2);
    check({tag, "_no_ok_before_capture"}, 32'(ok), 32'd0);
    wait_n(1);
    check({tag, "_nota_at_capture"}, 32'(nota), 32'(exp_n));
    check({tag, "_ok_low_at_capture"}, 32'(ok), 32'd0);
    check({tag, "_contagem"}, 32'(contagem), 32'(exp_c));
    wait_n(1);
    check({tag, "_ok_pulse"}, 32'(ok), 32'd1);
    wait_n(1);
    check({tag, "_ok_falls"}, 32'(ok), 32'd0);
  endtask

  task automatic press_hold();
    btn_ok = 1'b1;
    wait_n(D + 8);
    btn_ok = 1'b0;
    wait_n(D + 8);
  endtask

  // Scoreboard monitor: every ok pops one expected note
  initial begin
    prev_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ok = 1'b0;
      end else begin
        if (ok) begin
          ok_count++;
          check("ok_single_cycle", 32'(prev_ok), 32'd0);
          check("sb_ok_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_nota = exp_q.pop_front();
            check("sb_nota", 32'(nota), 32'(exp_nota));
          end
        end
        prev_ok = ok;
      end
    end
  end

  initial begin
    tests = 0; failed = 0; ok_count = 0;
    reset = 1'b1; btn_ok = 1'b0; sw_nota = 3'd0; sw_mod = 1'b0; fim = 1'b0;
    wait_n(3);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_nota", 32'(nota), 32'd0);
    check("rst_contagem", 32'(contagem), 32'd0);
    check("rst_cheio", 32'(cheio), 32'd0);
    reset = 1'b0;
    wait_n(2);

    // Clean press, code 0110
    sw_mod = 1'b0; sw_nota = 3'd6;
    exp_q.push_back(4'h6);
    timed_press("clean", 4'h6, 3'd1);
    btn_ok = 1'b0;
    wait_n(D + 8);

    // Bounce 1/0 every 3 cycles, then stable high; timing from the last rise
    sw_mod = 1'b1; sw_nota = 3'd3;
    exp_q.push_back(4'hB);
    oc = ok_count;
    for (int i = 0; i < 40; i++) begin
      btn_ok = ((i / 3) % 2 == 0);
      wait_n(1);
    end
    check("bounce_no_ok", 32'(ok_count), 32'(oc));
    timed_press("bounce", 4'hB, 3'd2);

    // Release bounce while held
    oc = ok_count;
    btn_ok = 1'b0;
    wait_n(5);
    btn_ok = 1'b1;
    wait_n(10);
    btn_ok = 1'b0;
    wait_n(D + 8);
    check("release_bounce_no_ok", 32'(ok_count), 32'(oc));
    check("release_bounce_contagem", 32'(contagem), 32'd2);

    // fim blocks a press; after fim drops a pause code is accepted
    fim = 1'b1; sw_mod = 1'b0; sw_nota = 3'd5;
    oc = ok_count;
    press_hold();
    check("fim_no_ok", 32'(ok_count), 32'(oc));
    check("fim_contagem", 32'(contagem), 32'd2);
    check("fim_nota_held", 32'(nota), 32'hB);
    fim = 1'b0; sw_mod = 1'b1; sw_nota = 3'd0;
    exp_q.push_back(4'h8);
    press_hold();
    check("after_fim_ok", 32'(ok_count), 32'(oc + 1));
    check("after_fim_contagem", 32'(contagem), 32'd3);
    check("after_fim_nota", 32'(nota), 32'h8);

    // Fill up to MAX_NOTAS, then a sixth press is rejected
    sw_mod = 1'b0; sw_nota = 3'd1;
    exp_q.push_back(4'h1);
    press_hold();
    check("four_cheio", 32'(cheio), 32'd0);
    sw_mod = 1'b1; sw_nota = 3'd7;
    exp_q.push_back(4'hF);
    press_hold();
    check("five_contagem", 32'(contagem), 32'd5);
    check("five_cheio", 32'(cheio), 32'd1);
    sw_mod = 1'b0; sw_nota = 3'd2;
    oc = ok_count;
    press_hold();
    check("sixth_no_ok", 32'(ok_count), 32'(oc));
    check("sixth_nota_held", 32'(nota), 32'hF);
    check("sixth_contagem", 32'(contagem), 32'd5);

    // Reset during PRESS_WAIT with the button held, then re-qualify from IDLE
    sw_mod = 1'b0; sw_nota = 3'd7;
    btn_ok = 1'b1;
    wait_n(12);
    reset = 1'b1;
    #1;
    check("midrst_ok", 32'(ok), 32'd0);
    check("midrst_nota", 32'(nota), 32'd0);
    check("midrst_contagem", 32'(contagem), 32'd0);
    check("midrst_cheio", 32'(cheio), 32'd0);
    exp_q.push_back(4'h7);
    wait_n(2);
    reset = 1'b0;
    wait_n(D + 3);
    check("postrst_no_ok_yet", 32'(ok), 32'd0);
    check("postrst_nota", 32'(nota), 32'h7);
    check("postrst_contagem", 32'(contagem), 32'd1);
    wait_n(1);
    check("postrst_ok_pulse", 32'(ok), 32'd1);
    wait_n(1);
    check("postrst_ok_falls", 32'(ok), 32'd0);
    btn_ok = 1'b0;
    wait_n(D + 8);

    check("sb_all_consumed", 32'(exp_q.size()), 32'd0);
    check("total_ok_pulses", 32'(ok_count), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
